// File: rtl/tetris_vga_pkg.sv
// Shared constants, render state encoding and pixel payload for the Tetris VGA path.
package tetris_vga_pkg;

    localparam int unsigned ROWS_DEF    = 23;
    localparam int unsigned COLS_DEF    = 10;
    localparam int unsigned CELL_PX_DEF = 4;
    localparam int unsigned X0_DEF      = 60;
    localparam int unsigned Y0_DEF      = 10;

    localparam logic [2:0] FG_COLOUR_DEF = 3'b111;
    localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

    // Pixel coordinates are formed at this width and truncated to the adapter's ports.
    localparam int unsigned COORD_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DRAW,
        S_DONE
    } render_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

endpackage

// File: rtl/cell_plotter.sv
// Walks one CELL_PX x CELL_PX square in raster order, one registered pixel per cycle.
module cell_plotter
    import tetris_vga_pkg::*;
#(
    parameter int unsigned CELL_PX = CELL_PX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [COORD_W-1:0] org_x,
    input  logic [COORD_W-1:0] org_y,
    input  logic [2:0]         fill,
    output pixel_t             pixel,
    output logic               plot,
    output logic               last_c
);

    localparam int unsigned PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CELL_PX - 1);

    logic [PW-1:0] px;
    logic [PW-1:0] py;

    // Final pixel of the square is being issued this cycle.
    assign last_c = go && (px == P_MAX) && (py == P_MAX);

    // px is the inner counter, py the outer; both wrap to 0 after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px    <= '0;
            py    <= '0;
            plot  <= 1'b0;
            pixel <= '0;
        end else begin
            plot <= go;
            if (go) begin
                pixel.x      <= 8'(org_x + COORD_W'(px));
                pixel.y      <= 7'(org_y + COORD_W'(py));
                pixel.colour <= fill;
                if (px == P_MAX) begin
                    px <= '0;
                    py <= (py == P_MAX) ? '0 : py + 1'b1;
                end else begin
                    px <= px + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_render_ctrl.sv
// Incremental playfield renderer: diffs each board row against a shadow of the screen
// and plots only changed cells (or all cells on a full redraw) into the VGA adapter.
module board_render_ctrl
    import tetris_vga_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned CELL_PX   = CELL_PX_DEF,
    parameter int unsigned X0        = X0_DEF,
    parameter int unsigned Y0        = Y0_DEF,
    parameter logic [2:0]  FG_COLOUR = FG_COLOUR_DEF,
    parameter logic [2:0]  BG_COLOUR = BG_COLOUR_DEF
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            start,
    input  logic            full_redraw,
    output logic [4:0]      row_sel,
    input  logic [COLS-1:0] row_data,
    output logic [7:0]      x,
    output logic [6:0]      y,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = 5;
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    render_state_e      state;
    logic               fr_q;
    logic [RW-1:0]      r;
    logic [CW-1:0]      c;
    logic [COLS-1:0]    row_q;
    logic [COLS-1:0]    diff_q;
    logic [COLS-1:0]    shadow [ROWS];

    logic [CW-1:0]      col_idx_c;
    logic [COORD_W-1:0] org_x_c;
    logic [COORD_W-1:0] org_y_c;
    logic [2:0]         fill_c;
    logic               draw_c;
    logic               last_c;
    logic               adv_c;
    pixel_t             pixel;

    // Column c counts from the left, which is the row word's MSB.
    assign col_idx_c = C_LAST - c;
    assign org_x_c   = COORD_W'(X0) + COORD_W'(c) * COORD_W'(CELL_PX);
    assign org_y_c   = COORD_W'(Y0) + COORD_W'(r) * COORD_W'(CELL_PX);
    assign fill_c    = row_q[col_idx_c] ? FG_COLOUR : BG_COLOUR;
    assign draw_c    = (state == S_DRAW);
    // Move to the next column after an unchanged SCAN or after a cell's last pixel.
    assign adv_c     = ((state == S_SCAN) && !diff_q[col_idx_c]) || last_c;

    assign row_sel = r;
    assign x       = pixel.x;
    assign y       = pixel.y;
    assign colour  = pixel.colour;

    cell_plotter #(
        .CELL_PX (CELL_PX)
    ) u_plotter (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .go     (draw_c),
        .org_x  (org_x_c),
        .org_y  (org_y_c),
        .fill   (fill_c),
        .pixel  (pixel),
        .plot   (plot),
        .last_c (last_c)
    );

    // Render sequencer: row load, column scan, cell draw, shadow update and status flags.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            fr_q   <= 1'b0;
            r      <= '0;
            c      <= '0;
            row_q  <= '0;
            diff_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < int'(ROWS); i++) begin
                shadow[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (adv_c) begin
                if (last_c) begin
                    shadow[r][col_idx_c] <= row_q[col_idx_c];
                end
                if (c != C_LAST) begin
                    c     <= c + 1'b1;
                    state <= S_SCAN;
                end else if (r != R_LAST) begin
                    r     <= r + 1'b1;
                    state <= S_LOAD;
                end else begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            fr_q  <= full_redraw;
                            r     <= '0;
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        // Whole row is captured at once so a cell run never sees a torn row.
                        row_q  <= row_data;
                        diff_q <= fr_q ? '1 : (row_data ^ shadow[r]);
                        c      <= '0;
                        state  <= S_SCAN;
                    end
                    // Only reached with a changed column; unchanged ones take adv_c.
                    S_SCAN:  state <= S_DRAW;
                    S_DRAW:  state <= S_DRAW;
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_render_ctrl.sv
// Randomised bench for board_render_ctrl with a per-cycle behavioural model of a render pass.
module tb_board_render_ctrl;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       full_redraw;
    logic [4:0] row_sel;
    logic [9:0] row_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    logic [9:0] board [23];
    logic [9:0] msh   [23];

    int checks, errors;
    int gcyc, plot_tot, fg_bad, done_g;
    int last_x, last_y, last_col;
    bit chk_en;

    bit exp_busy, exp_done, exp_plot;
    int exp_x, exp_y, exp_col;
    bit pend_v;
    int pend_x, pend_y, pend_c;

    int pcyc, poke_cyc, chg_cyc, chg_row, m_nchg;
    logic [9:0] chg_val;

    board_render_ctrl dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start),
        .full_redraw (full_redraw),
        .row_sel     (row_sel),
        .row_data    (row_data),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    assign row_data = (row_sel < 5'd23) ? board[row_sel] : 10'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle comparison against the model, plus DUT-side tallies.
    task automatic cmp();
        bit ok;
        bit in_col;
        gcyc++;
        if (plot === 1'b1) begin
            plot_tot++;
            last_x   = int'(x);
            last_y   = int'(y);
            last_col = int'(colour);
            in_col   = (x >= 8'd76) && (x <= 8'd79);
            if (!((colour == 3'd7 && in_col) || (colour == 3'd0 && !in_col))) fg_bad++;
        end
        if (done === 1'b1) done_g = gcyc;
        if (chk_en) begin
            checks++;
            ok = (busy === exp_busy) && (done === exp_done) && (plot === exp_plot);
            if (ok && exp_plot)
                ok = (int'(x) == exp_x) && (int'(y) == exp_y) && (int'(colour) == exp_col);
            if (!ok) begin
                errors++;
                $display("FAIL cycle %0d busy/done/plot/x/y/colour got %b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
                         gcyc, busy, done, plot, x, y, colour,
                         exp_busy, exp_done, exp_plot, exp_x, exp_y, exp_col);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp();
        @(posedge clk);
        #1;
    endtask

    // Set this cycle's expectations; a pixel chosen now is visible on the outputs next cycle.
    task automatic expect_cycle(input bit b, input bit d, input bit dv,
                                input int px, input int py, input int pc);
        exp_busy = b;
        exp_done = d;
        exp_plot = pend_v;
        exp_x    = pend_x;
        exp_y    = pend_y;
        exp_col  = pend_c;
        pend_v   = dv;
        pend_x   = px;
        pend_y   = py;
        pend_c   = pc;
        pcyc++;
        start = (pcyc == poke_cyc);
        if (pcyc == chg_cyc) board[chg_row] = chg_val;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    // One render pass: model walks rows/columns/pixels; the board is read when the DUT samples it.
    task automatic run_pass(input bit fr, input int poke, input int chg_at, input int crow,
                            input logic [9:0] cval, output int len, output int nplots);
        logic [9:0] rowv, diff;
        int sg, p0;
        poke_cyc = poke;
        chg_cyc  = chg_at;
        chg_row  = crow;
        chg_val  = cval;
        tick();
        pcyc = -1;
        expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        start       = 1'b1;
        full_redraw = fr;
        sg     = gcyc;
        p0     = plot_tot;
        done_g = -1;
        m_nchg = 0;
        rowv   = '0;
        diff   = '0;
        for (int r = 0; r < 23; r++) begin
            tick();
            expect_cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (c == 0) begin
                    rowv = board[r];
                    diff = fr ? 10'h3FF : (rowv ^ msh[r]);
                end
                expect_cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
                if (diff[9-c]) begin
                    for (int py = 0; py < 4; py++) begin
                        for (int px = 0; px < 4; px++) begin
                            tick();
                            expect_cycle(1'b1, 1'b0, 1'b1, 60 + 4*c + px, 10 + 4*r + py,
                                         rowv[9-c] ? 7 : 0);
                        end
                    end
                    msh[r][9-c] = rowv[9-c];
                    m_nchg++;
                end
            end
        end
        tick();
        expect_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        tick();
        expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        len      = done_g - sg - 1;
        nplots   = plot_tot - p0;
        poke_cyc = -10;
        chg_cyc  = -10;
    endtask

    initial begin
        int len, np, fb0;
        logic [9:0] v;
        resetn = 1'b0; start = 1'b0; full_redraw = 1'b0; chk_en = 1'b0;
        checks = 0; errors = 0; gcyc = 0; plot_tot = 0; fg_bad = 0; done_g = -1;
        last_x = 0; last_y = 0; last_col = 0;
        exp_busy = 0; exp_done = 0; exp_plot = 0; exp_x = 0; exp_y = 0; exp_col = 0;
        pend_v = 0; pend_x = 0; pend_y = 0; pend_c = 0;
        pcyc = 0; poke_cyc = -10; chg_cyc = -10; chg_row = 0; chg_val = '0; m_nchg = 0;
        for (int i = 0; i < 23; i++) begin board[i] = '0; msh[i] = '0; end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_row_sel", int'(row_sel), 0);
        resetn = 1'b1;
        expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk_en = 1'b1;
        idle(3);

        // Full redraw of a single occupied column.
        for (int i = 0; i < 23; i++) board[i] = 10'b0000100000;
        fb0 = fg_bad;
        run_pass(1'b1, -10, -10, 0, '0, len, np);
        chk("A_len", len, 3934);
        chk("A_plots", np, 3680);
        chk("A_colour_map", fg_bad - fb0, 0);

        // Unchanged board; a start in the DONE cycle is dropped.
        run_pass(1'b0, 254, -10, 0, '0, len, np);
        chk("B_len", len, 254);
        chk("B_plots", np, 0);
        idle(20);

        // Clear, then a single cell at the bottom-left.
        for (int i = 0; i < 23; i++) board[i] = '0;
        run_pass(1'b0, -10, -10, 0, '0, len, np);
        chk("C_clear_len", len, 622);
        board[22] = 10'b1000000000;
        run_pass(1'b0, -10, -10, 0, '0, len, np);
        chk("C_len", len, 270);
        chk("C_plots", np, 16);
        chk("C_last_x", last_x, 63);
        chk("C_last_y", last_y, 101);
        chk("C_last_colour", last_col, 7);

        // Start while busy is ignored.
        board[3]  = 10'($urandom);
        board[15] = 10'($urandom);
        run_pass(1'b0, 100, -10, 0, '0, len, np);
        chk("D_len", len, 254 + 16*m_nchg);
        idle(30);

        // Row 0 changes after its load: old value now, the new cells next pass.
        board[0] = 10'b0000000011;
        run_pass(1'b0, -10, 5, 0, 10'b1100000101, len, np);
        chk("E_cur_plots", np, 32);
        run_pass(1'b0, -10, -10, 0, '0, len, np);
        chk("E_next_plots", np, 64);

        // Randomised passes with stray starts and mid-pass board edits.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 3)) board[$urandom_range(0, 22)] = 10'($urandom);
            v = 10'($urandom);
            run_pass(($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 250)) : -10,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 240)) : -10,
                     int'($urandom_range(0, 22)), v, len, np);
            chk("R_len", len, 254 + 16*m_nchg);
            chk("R_plots", np, 16*m_nchg);
            idle(int'($urandom_range(1, 8)));
        end

        // Reset in the middle of a cell, then full redraw recovers.
        for (int i = 0; i < 23; i++) board[i] = 10'($urandom);
        tick();
        expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        start = 1'b1;
        full_redraw = 1'b1;
        tick();
        start  = 1'b0;
        chk_en = 1'b0;
        repeat (299) tick();
        chk("pre_rst_plot", int'(plot), 1);
        chk("pre_rst_busy", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 23; i++) msh[i] = '0;
        pend_v = 1'b0;
        expect_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk_en = 1'b1;
        idle(2);
        run_pass(1'b1, -10, -10, 0, '0, len, np);
        chk("F_len", len, 3934);
        chk("F_plots", np, 3680);
        idle(5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
